// File: rtl/mycpu_cp0_pkg.sv
// CP0 register numbers, exception codes and TLB entry packing shared by the
// CP0 register file, the TLB and the pipeline.
package mycpu_cp0_pkg;
  localparam logic [4:0] CP0_INDEX    = 5'd0;
  localparam logic [4:0] CP0_RANDOM   = 5'd1;
  localparam logic [4:0] CP0_ENTRYLO0 = 5'd2;
  localparam logic [4:0] CP0_ENTRYLO1 = 5'd3;
  localparam logic [4:0] CP0_CONTEXT  = 5'd4;
  localparam logic [4:0] CP0_WIRED    = 5'd6;
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_ENTRYHI  = 5'd10;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  // {vpn2, asid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1}
  localparam int TLB_ENTRY_W = 78;
  localparam int TE_VPN2 = 59;
  localparam int TE_ASID = 51;
  localparam int TE_G    = 50;
  localparam int TE_PFN0 = 30;
  localparam int TE_C0   = 27;
  localparam int TE_D0   = 26;
  localparam int TE_V0   = 25;
  localparam int TE_PFN1 = 5;
  localparam int TE_C1   = 2;
  localparam int TE_D1   = 1;
  localparam int TE_V1   = 0;

  // Same bit layout as EntryLo[25:0]
  typedef struct packed {
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
    logic        g;
  } entrylo_t;

  function automatic logic is_tlb_exc(input logic [4:0] code);
    return code == EXC_MOD || code == EXC_TLBL || code == EXC_TLBS;
  endfunction

  function automatic logic loads_badvaddr(input logic [4:0] code);
    return is_tlb_exc(code) || code == EXC_ADEL || code == EXC_ADES;
  endfunction
endpackage

// File: rtl/cp0_mmu_regs_if.sv
// Commit/read bus between the WB/EX stages (master) and the CP0 register file (slave).
interface cp0_mmu_regs_if
  import mycpu_cp0_pkg::*;
#(
  parameter int TLBNUM = 16
);
  localparam int IDX_W = $clog2(TLBNUM);

  logic [4:0]             raddr;
  logic [31:0]            rdata;
  logic                   mtc0_we;
  logic [4:0]             mtc0_addr;
  logic [31:0]            mtc0_wdata;
  logic                   ex_valid;
  logic [4:0]             ex_code;
  logic                   ex_bd;
  logic [31:0]            ex_pc;
  logic [31:0]            ex_badvaddr;
  logic                   eret;
  logic [5:0]             hw_int;
  logic                   tlbp_valid;
  logic                   tlbp_found;
  logic [IDX_W-1:0]       tlbp_index;
  logic                   tlbr_valid;
  logic [TLB_ENTRY_W-1:0] tlbr_entry;
  logic                   int_req;
  logic                   exl;
  logic [31:0]            epc;
  logic [IDX_W-1:0]       tlb_index;
  logic [IDX_W-1:0]       tlb_random;
  logic [TLB_ENTRY_W-1:0] tlb_entry;

  modport master (
    output raddr, mtc0_we, mtc0_addr, mtc0_wdata, ex_valid, ex_code, ex_bd, ex_pc,
           ex_badvaddr, eret, hw_int, tlbp_valid, tlbp_found, tlbp_index, tlbr_valid,
           tlbr_entry,
    input  rdata, int_req, exl, epc, tlb_index, tlb_random, tlb_entry
  );

  modport slave (
    input  raddr, mtc0_we, mtc0_addr, mtc0_wdata, ex_valid, ex_code, ex_bd, ex_pc,
           ex_badvaddr, eret, hw_int, tlbp_valid, tlbp_found, tlbp_index, tlbr_valid,
           tlbr_entry,
    output rdata, int_req, exl, epc, tlb_index, tlb_random, tlb_entry
  );
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances once every COUNT_DIV cycles, TI latches on match.
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);
  localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(COUNT_DIV - 1);

  logic [DIV_W-1:0] div;

  always_ff @(posedge clk) begin
    if (reset) begin
      div     <= '0;
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      if (count_we) begin
        count <= wdata;
        div   <= '0;
      end else if (div == DIV_MAX) begin
        count <= count + 32'd1;
        div   <= '0;
      end else begin
        div <= div + 1'b1;
      end
      if (compare_we) compare <= wdata;
      // A Compare write acknowledges the timer even on a same-cycle match
      if (compare_we)              ti <= 1'b0;
      else if (count == compare)   ti <= 1'b1;
    end
  end
endmodule

// File: rtl/cp0_mmu_regs.sv
// CP0 register file with MMU registers (Index/Random/EntryLo/Context/Wired/EntryHi),
// exception/eret commit, Count/Compare timer and registered interrupt request.
module cp0_mmu_regs
  import mycpu_cp0_pkg::*;
#(
  parameter int TLBNUM    = 16,
  parameter int IDX_W     = $clog2(TLBNUM),
  parameter int COUNT_DIV = 2
) (
  input logic           clk,
  input logic           reset,
  cp0_mmu_regs_if.slave bus
);
  localparam logic [IDX_W-1:0] RAND_TOP = IDX_W'(TLBNUM - 1);

  logic [31:0] wd;
  logic we_index, we_lo0, we_lo1, we_ctx, we_wired, we_count, we_hi, we_compare;
  logic we_status, we_cause, we_epc;
  logic ex, ex_first, ex_tlb, ex_bva;
  logic [TLB_ENTRY_W-1:0] te;

  logic             idx_p;
  logic [IDX_W-1:0] idx, random, wired;
  entrylo_t         lo0, lo1;
  logic [8:0]       ptebase;
  logic [18:0]      badvpn2, vpn2;
  logic [7:0]       asid, im, ip;
  logic [31:0]      badvaddr, epc, count, compare;
  logic             exl, ie, bd, ti, irq;
  logic [5:0]       hw_q;
  logic [1:0]       ip_sw;
  logic [4:0]       exccode;

  assign wd         = bus.mtc0_wdata;
  assign we_index   = bus.mtc0_we && bus.mtc0_addr == CP0_INDEX;
  assign we_lo0     = bus.mtc0_we && bus.mtc0_addr == CP0_ENTRYLO0;
  assign we_lo1     = bus.mtc0_we && bus.mtc0_addr == CP0_ENTRYLO1;
  assign we_ctx     = bus.mtc0_we && bus.mtc0_addr == CP0_CONTEXT;
  assign we_wired   = bus.mtc0_we && bus.mtc0_addr == CP0_WIRED;
  assign we_count   = bus.mtc0_we && bus.mtc0_addr == CP0_COUNT;
  assign we_hi      = bus.mtc0_we && bus.mtc0_addr == CP0_ENTRYHI;
  assign we_compare = bus.mtc0_we && bus.mtc0_addr == CP0_COMPARE;
  assign we_status  = bus.mtc0_we && bus.mtc0_addr == CP0_STATUS;
  assign we_cause   = bus.mtc0_we && bus.mtc0_addr == CP0_CAUSE;
  assign we_epc     = bus.mtc0_we && bus.mtc0_addr == CP0_EPC;

  assign ex       = bus.ex_valid;
  assign ex_first = ex & ~exl;
  assign ex_tlb   = ex & is_tlb_exc(bus.ex_code);
  assign ex_bva   = ex & loads_badvaddr(bus.ex_code);
  assign te       = bus.tlbr_entry;

  // TI feeds IP7 directly so a timer match raises int_req one cycle later
  assign ip = {hw_q[5] | ti, hw_q[4:0], ip_sw};

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .count_we   (we_count),
    .compare_we (we_compare),
    .wdata      (wd),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_p    <= 1'b0;
      idx      <= '0;
      random   <= RAND_TOP;
      wired    <= '0;
      lo0      <= '0;
      lo1      <= '0;
      ptebase  <= '0;
      badvpn2  <= '0;
      vpn2     <= '0;
      asid     <= '0;
      badvaddr <= '0;
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      hw_q     <= '0;
      ip_sw    <= '0;
      exccode  <= '0;
      epc      <= '0;
      irq      <= 1'b0;
    end else begin
      if (we_index) idx <= wd[IDX_W-1:0];
      else if (bus.tlbp_valid) begin
        idx_p <= ~bus.tlbp_found;
        if (bus.tlbp_found) idx <= bus.tlbp_index;
      end

      // Random sweeps TLBNUM-1 down to Wired, then wraps back to the top
      if (we_wired || random <= wired) random <= RAND_TOP;
      else                             random <= random - 1'b1;
      if (we_wired) wired <= wd[IDX_W-1:0];

      if (we_lo0) lo0 <= entrylo_t'(wd[25:0]);
      else if (bus.tlbr_valid)
        lo0 <= '{pfn: te[TE_PFN0 +: 20], c: te[TE_C0 +: 3], d: te[TE_D0], v: te[TE_V0], g: te[TE_G]};
      if (we_lo1) lo1 <= entrylo_t'(wd[25:0]);
      else if (bus.tlbr_valid)
        lo1 <= '{pfn: te[TE_PFN1 +: 20], c: te[TE_C1 +: 3], d: te[TE_D1], v: te[TE_V1], g: te[TE_G]};

      if (we_ctx) ptebase <= wd[31:23];
      if (ex_tlb) badvpn2 <= bus.ex_badvaddr[31:13];

      if (ex_tlb) vpn2 <= bus.ex_badvaddr[31:13];
      else if (we_hi) begin
        vpn2 <= wd[31:13];
        asid <= wd[7:0];
      end else if (bus.tlbr_valid) begin
        vpn2 <= te[TE_VPN2 +: 19];
        asid <= te[TE_ASID +: 8];
      end

      if (ex_bva) badvaddr <= bus.ex_badvaddr;

      if (ex)             exl <= 1'b1;
      else if (we_status) exl <= wd[1];
      else if (bus.eret)  exl <= 1'b0;
      if (we_status) begin
        im <= wd[15:8];
        ie <= wd[0];
      end

      if (ex)       exccode <= bus.ex_code;
      if (ex_first) bd      <= bus.ex_bd;
      if (we_cause) ip_sw   <= wd[9:8];
      hw_q <= bus.hw_int;

      // A nested exception (EXL already set) keeps the original return address
      if (ex_first)          epc <= bus.ex_bd ? bus.ex_pc - 32'd4 : bus.ex_pc;
      else if (!ex && we_epc) epc <= wd;

      irq <= ie & ~exl & (|(ip & im));
    end
  end

  always_comb begin
    bus.rdata = '0;
    case (bus.raddr)
      CP0_INDEX:    bus.rdata = {idx_p, 31'(idx)};
      CP0_RANDOM:   bus.rdata = 32'(random);
      CP0_ENTRYLO0: bus.rdata = 32'(lo0);
      CP0_ENTRYLO1: bus.rdata = 32'(lo1);
      CP0_CONTEXT:  bus.rdata = {ptebase, badvpn2, 4'b0};
      CP0_WIRED:    bus.rdata = 32'(wired);
      CP0_BADVADDR: bus.rdata = badvaddr;
      CP0_COUNT:    bus.rdata = count;
      CP0_ENTRYHI:  bus.rdata = {vpn2, 5'b0, asid};
      CP0_COMPARE:  bus.rdata = compare;
      CP0_STATUS:   bus.rdata = {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
      CP0_CAUSE:    bus.rdata = {bd, ti, 14'b0, ip, 1'b0, exccode, 2'b0};
      CP0_EPC:      bus.rdata = epc;
      default:      bus.rdata = '0;
    endcase
  end

  assign bus.int_req    = irq;
  assign bus.exl        = exl;
  assign bus.epc        = epc;
  assign bus.tlb_index  = idx;
  assign bus.tlb_random = random;
  assign bus.tlb_entry  = {vpn2, asid, lo0.g & lo1.g, lo0.pfn, lo0.c, lo0.d, lo0.v,
                           lo1.pfn, lo1.c, lo1.d, lo1.v};
endmodule

// File: tb/tb_cp0_mmu_regs.sv
// Directed + randomized bench for cp0_mmu_regs against a word-level register model.
module tb_cp0_mmu_regs;
  localparam int TLBNUM = 16;
  localparam int IDX_W  = 4;
  localparam int CDIV   = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #50 clk = ~clk;

  cp0_mmu_regs_if #(.TLBNUM(TLBNUM)) bus ();
  cp0_mmu_regs #(.TLBNUM(TLBNUM), .IDX_W(IDX_W), .COUNT_DIV(CDIV)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // Model: architectural register words by CP0 number, Cause kept without IP[7:2]
  logic [31:0] m [32];
  int          rnd;
  int          div;
  logic [5:0]  hwq;
  logic        irq;

  task automatic chk(input string tag, input logic [77:0] obs, input logic [77:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mask_of(input logic [4:0] a);
    case (a)
      5'd0, 5'd6:          return 32'(2**IDX_W - 1);
      5'd2, 5'd3:          return 32'h03FF_FFFF;
      5'd4:                return 32'hFF80_0000;
      5'd9, 5'd11, 5'd14:  return 32'hFFFF_FFFF;
      5'd10:               return 32'hFFFF_E0FF;
      5'd12:               return 32'h0000_FF03;
      5'd13:               return 32'h0000_0300;
      default:             return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] mread(input int r);
    case (r)
      1:  return 32'(rnd);
      0, 2, 3, 4, 6, 8, 9, 10, 11, 12, 14: return m[r];
      13: return m[13] | (32'(hwq[5] | m[13][30]) << 15) | (32'(hwq[4:0]) << 10);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [77:0] mentry();
    return {m[10][31:13], m[10][7:0], m[2][0] & m[3][0], m[2][25:1], m[3][25:1]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m[i] = 32'h0;
    m[12] = 32'h0040_0000;
    rnd = TLBNUM - 1;
    div = 0;
    hwq = '0;
    irq = 1'b0;
  endtask

  task automatic model_edge();
    logic [31:0] o [32];
    logic [7:0]  ipv;
    logic [4:0]  a, c;
    logic [77:0] e;
    logic [31:0] bva;
    if (reset) begin
      model_reset();
      return;
    end
    o = m;
    ipv = 8'(mread(13) >> 8);
    irq = o[12][0] & ~o[12][1] & (|(ipv & o[12][15:8]));
    if (div == CDIV - 1) begin div = 0; m[9] = o[9] + 32'd1; end
    else div++;
    if (o[9] == o[11]) m[13][30] = 1'b1;
    if ((bus.mtc0_we && bus.mtc0_addr == 5'd6) || rnd <= int'(o[6])) rnd = TLBNUM - 1;
    else rnd--;
    hwq = bus.hw_int;
    if (bus.tlbp_valid)
      m[0] = bus.tlbp_found ? 32'(bus.tlbp_index) : (o[0] | 32'h8000_0000);
    if (bus.tlbr_valid) begin
      e = bus.tlbr_entry;
      m[10] = {e[77:59], 5'b0, e[58:51]};
      m[2]  = {6'b0, e[49:25], e[50]};
      m[3]  = {6'b0, e[24:0], e[50]};
    end
    if (bus.mtc0_we) begin
      a = bus.mtc0_addr;
      m[a] = (m[a] & ~mask_of(a)) | (bus.mtc0_wdata & mask_of(a));
      if (a == 5'd9)  div = 0;
      if (a == 5'd11) m[13][30] = 1'b0;
    end
    if (bus.ex_valid) begin
      c = bus.ex_code;
      bva = bus.ex_badvaddr;
      m[13][6:2] = c;
      if (!o[12][1]) begin
        m[14] = bus.ex_bd ? bus.ex_pc - 32'd4 : bus.ex_pc;
        m[13][31] = bus.ex_bd;
      end
      m[12][1] = 1'b1;
      if (c >= 5'd1 && c <= 5'd5) m[8] = bva;
      if (c >= 5'd1 && c <= 5'd3) begin
        m[4][22:4]   = bva[31:13];
        m[10][31:13] = bva[31:13];
      end
    end else if (bus.eret) begin
      m[12][1] = 1'b0;
    end
  endtask

  task automatic check_all();
    for (int r = 0; r <= 16; r++) begin
      bus.raddr = 5'(r);
      #1;
      chk($sformatf("rd%0d", r), 78'(bus.rdata), 78'(mread(r)));
    end
    chk("int_req", 78'(bus.int_req), 78'(irq));
    chk("exl", 78'(bus.exl), 78'(m[12][1]));
    chk("epc", 78'(bus.epc), 78'(m[14]));
    chk("tlb_index", 78'(bus.tlb_index), 78'(m[0][IDX_W-1:0]));
    chk("tlb_random", 78'(bus.tlb_random), 78'(rnd));
    chk("tlb_entry", bus.tlb_entry, mentry());
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic rd(input logic [4:0] r, output logic [31:0] v);
    bus.raddr = r;
    #1;
    v = bus.rdata;
  endtask

  task automatic clr();
    bus.mtc0_we = 1'b0; bus.mtc0_addr = '0; bus.mtc0_wdata = '0;
    bus.ex_valid = 1'b0; bus.ex_code = '0; bus.ex_bd = 1'b0; bus.ex_pc = '0;
    bus.ex_badvaddr = '0; bus.eret = 1'b0;
    bus.tlbp_valid = 1'b0; bus.tlbp_found = 1'b0; bus.tlbp_index = '0;
    bus.tlbr_valid = 1'b0; bus.tlbr_entry = '0;
  endtask

  task automatic w(input logic [4:0] a, input logic [31:0] d);
    clr();
    bus.mtc0_we = 1'b1; bus.mtc0_addr = a; bus.mtc0_wdata = d;
    cycle();
    clr();
  endtask

  task automatic exc(input logic [4:0] code, input logic bd, input logic [31:0] pc,
                     input logic [31:0] bva, input logic with_eret);
    clr();
    bus.ex_valid = 1'b1; bus.ex_code = code; bus.ex_bd = bd; bus.ex_pc = pc;
    bus.ex_badvaddr = bva; bus.eret = with_eret;
    cycle();
    clr();
  endtask

  task automatic do_eret();
    clr();
    bus.eret = 1'b1;
    cycle();
    clr();
  endtask

  initial begin
    logic [31:0] v;
    logic [77:0] e;
    int op;
    clr();
    bus.hw_int = '0;
    bus.raddr = '0;
    model_reset();
    cycle();
    cycle();
    rd(5'd1, v);  chk("reset_random", 78'(v), 78'(15));
    rd(5'd12, v); chk("reset_status", 78'(v), 78'(32'h0040_0000));
    chk("reset_int_req", 78'(bus.int_req), 78'(0));
    reset = 1'b0;

    // Random walk with Wired=3, then pinned at the top with Wired=15
    w(5'd6, 32'd3);
    for (int k = 0; k < 14; k++) begin
      rd(5'd1, v);
      chk("random_seq", 78'(v), 78'((k < 13) ? 15 - k : 15));
      cycle();
    end
    w(5'd6, 32'd15);
    for (int k = 0; k < 4; k++) begin
      rd(5'd1, v);
      chk("random_pinned", 78'(v), 78'(15));
      cycle();
    end

    // Timer: Count=0, Compare=5, Status IM7|IE
    w(5'd9, 32'd0);
    w(5'd11, 32'd5);
    w(5'd12, 32'h0000_8001);
    for (int t = 3; t <= 13; t++) begin
      cycle();
      rd(5'd13, v);
      chk("ti_rise", 78'(v[30]), 78'(t >= 11));
      chk("int_req_ti", 78'(bus.int_req), 78'(t >= 12));
    end
    w(5'd11, 32'h0000_0100);
    rd(5'd13, v);
    chk("ti_clear", 78'(v[30]), 78'(0));
    chk("int_req_lag", 78'(bus.int_req), 78'(1));
    cycle();
    chk("int_req_clear", 78'(bus.int_req), 78'(0));

    // TLBL in a delay slot, then nested TLBS, eret, ex+eret
    exc(5'd2, 1'b1, 32'h8000_0104, 32'h1234_5678, 1'b0);
    rd(5'd14, v); chk("ex_epc", 78'(v), 78'(32'h8000_0100));
    rd(5'd13, v); chk("ex_cause", 78'(v), 78'(32'h8000_0008));
    rd(5'd8, v);  chk("ex_badvaddr", 78'(v), 78'(32'h1234_5678));
    rd(5'd4, v);  chk("ex_context", 78'(v), 78'(32'h0009_1A20));
    rd(5'd10, v); chk("ex_entryhi", 78'(v), 78'(32'h1234_4000));
    exc(5'd3, 1'b0, 32'h8000_0200, 32'h0000_1000, 1'b0);
    rd(5'd14, v); chk("nest_epc", 78'(v), 78'(32'h8000_0100));
    rd(5'd13, v); chk("nest_cause", 78'(v), 78'(32'h8000_000C));
    do_eret();
    chk("eret_exl", 78'(bus.exl), 78'(0));
    exc(5'd4, 1'b0, 32'h8000_0300, 32'h0000_0002, 1'b1);
    chk("ex_eret_exl", 78'(bus.exl), 78'(1));
    do_eret();

    // tlbp miss/hit, tlbr with global entry
    clr(); bus.tlbp_valid = 1'b1; bus.tlbp_found = 1'b0; bus.tlbp_index = 4'd9; cycle(); clr();
    rd(5'd0, v); chk("tlbp_miss", 78'(v), 78'(32'h8000_0000));
    clr(); bus.tlbp_valid = 1'b1; bus.tlbp_found = 1'b1; bus.tlbp_index = 4'd7; cycle(); clr();
    rd(5'd0, v); chk("tlbp_hit", 78'(v), 78'(32'h0000_0007));
    e = 78'({$urandom, $urandom, $urandom});
    e[50] = 1'b1;
    clr(); bus.tlbr_valid = 1'b1; bus.tlbr_entry = e; cycle(); clr();
    rd(5'd2, v); chk("tlbr_g0", 78'(v[0]), 78'(1));
    rd(5'd3, v); chk("tlbr_g1", 78'(v[0]), 78'(1));
    chk("tlbr_entry", bus.tlb_entry, e);

    // Randomized mix, with one mid-run reset
    for (int i = 0; i < 400; i++) begin
      clr();
      bus.hw_int = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      reset = (i == 200);
      op = int'($urandom_range(0, 9));
      case (op)
        0, 1, 2, 3: begin
          bus.mtc0_we = 1'b1;
          bus.mtc0_addr = 5'($urandom_range(0, 16));
          bus.mtc0_wdata = $urandom;
          if (bus.mtc0_addr == 5'd11 && $urandom_range(0, 1) == 1)
            bus.mtc0_wdata = m[9] + 32'($urandom_range(0, 4));
        end
        4, 8: begin
          bus.ex_valid = 1'b1;
          bus.ex_code = ($urandom_range(0, 2) != 0) ? 5'($urandom_range(1, 5)) : 5'($urandom);
          bus.ex_bd = 1'($urandom);
          bus.ex_pc = $urandom;
          bus.ex_badvaddr = $urandom;
          bus.eret = (op == 8);
        end
        5: bus.eret = 1'b1;
        6: begin
          bus.tlbp_valid = 1'b1;
          bus.tlbp_found = 1'($urandom);
          bus.tlbp_index = 4'($urandom_range(0, 15));
        end
        7: begin
          bus.tlbr_valid = 1'b1;
          bus.tlbr_entry = 78'({$urandom, $urandom, $urandom});
        end
        default: ;
      endcase
      cycle();
    end
    reset = 1'b0;
    clr();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
